// File: rtl/console_uart_controller.sv
// Console peripheral: register-mapped character FIFO drained by an 8N1 UART transmitter.
// Status (index 1) and occupancy (index 2) let software poll before writing.
module console_uart_controller #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx
);

    localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0]          BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]          BAUD_ONE    = BAUD_W'(1);
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE     = FIFO_ADDR_WIDTH'(1);
    localparam logic [FIFO_ADDR_WIDTH:0]   COUNT_ONE   = (FIFO_ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    logic [7:0]                 fifo_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FIFO_ADDR_WIDTH:0]   count_reg, count_next;
    logic                       overflow_reg, overflow_next;

    tx_state_t                  state_reg, state_next;
    logic [BAUD_W-1:0]          baud_reg, baud_next;
    logic [2:0]                 bit_reg, bit_next;
    logic [7:0]                 shift_reg, shift_next;
    logic                       tx_reg, tx_next;

    logic push_req, push_ok, pop, clear_req, full, fifo_empty, tx_idle;

    // Count is one bit wider than the pointers, so its MSB alone means full.
    assign full       = count_reg[FIFO_ADDR_WIDTH];
    assign fifo_empty = (count_reg == '0);
    assign tx_idle    = fifo_empty && (state_reg == ST_IDLE);

    assign push_req  = register_write && (register_index == 7'd0);
    assign clear_req = register_write && (register_index == 7'd1) && register_write_value[2];
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    state_next = ST_START;
                    baud_next  = BAUD_RELOAD;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_reg == '0) begin
                    state_next = ST_DATA;
                    bit_next   = 3'd0;
                    baud_next  = BAUD_RELOAD;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        tx_next  = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_reg == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg];
                        state_next = ST_START;
                        baud_next  = BAUD_RELOAD;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
        // A dropped character outranks a simultaneous clear.
        if (push_req && !push_ok) begin
            overflow_next = 1'b1;
        end else if (clear_req) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= register_write_value[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_reg      <= 3'd0;
            shift_reg    <= 8'd0;
            tx_reg       <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
        end
    end

    assign uart_tx = tx_reg;

    always_comb begin
        register_read_value = 16'd0;
        if (register_read) begin
            case (register_index)
                7'd1:    register_read_value = {13'd0, overflow_reg, full, tx_idle};
                7'd2:    register_read_value = {{(15 - FIFO_ADDR_WIDTH){1'b0}}, count_reg};
                default: register_read_value = 16'd0;
            endcase
        end
    end

endmodule
